prog_boot_sequencer: RTL and testbench

Synthesizable replacement for the simulation-only memory preload and run-control sequence around cpu_new. It streams words from a valid/ready source into NUM_CH external memory write ports (channel 0 first), optionally zero-fills each memory to depth, and then raises the CPU enable. It then counts execution cycles, detects the STOP opcode, and reports the stop code, cycle count and timeout status. It sits between a host/ROM streamer and cpu_new's addr_ext*/wen_ext*/wdata_ext* ports.

---
 rtl/prog_boot_sequencer_pkg.sv | 26 ++
 rtl/prog_run_monitor.sv | 52 +++++
 rtl/prog_boot_sequencer.sv | 143 ++++++++++++++
 tb/tb_prog_boot_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_boot_sequencer_pkg.sv
// Shared types and helpers for the boot sequencer and its run monitor.
package prog_boot_sequencer_pkg;

    // Upper bound on channels that the packed depth vector can describe.
    localparam int unsigned MAX_CH = 16;

    // Default opcode (instr[31:26]) that ends CPU execution.
    localparam logic [5:0] STOP_OPC_DEF = 6'b111110;

    // Sequencer states; encodings kept identical to the legacy localparams.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_FILL = 3'd2,
        ST_GAP  = 3'd3,
        ST_RUN  = 3'd4,
        ST_DONE = 3'd5
    } boot_state_e;

    // Depth in words of channel ch; ch0 occupies the least significant slice.
    function automatic logic [15:0] ch_depth(input logic [16*MAX_CH-1:0] words,
                                             input int unsigned ch);
        return words[ch*16 +: 16];
    endfunction

endpackage

// File: rtl/prog_run_monitor.sv
// RUN-phase monitor: counts enabled cycles, spots the STOP opcode and the
// cycle limit, and holds the stop code / timeout result until cleared.
module prog_run_monitor
    import prog_boot_sequencer_pkg::*;
#(
    parameter logic [5:0]  STOP_OPC   = STOP_OPC_DEF,
    parameter int unsigned MAX_CYCLES = 1000000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [31:0]      instr,
    output logic             finish,
    output logic             timeout,
    output logic [1:0]       stop_code,
    output logic [CNT_W-1:0] cycle_count
);

    // The limit fires in the enabled cycle that brings the count to MAX_CYCLES.
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(MAX_CYCLES - 1);

    logic stop_hit;
    logic limit_hit;
    logic unused_instr_bits;

    // End-of-run detection; STOP takes priority over the limit.
    always_comb begin
        stop_hit          = enable && (instr[31:26] == STOP_OPC);
        limit_hit         = enable && (cycle_count == LIMIT_M1);
        finish            = stop_hit || limit_hit;
        unused_instr_bits = ^instr[25:2];
    end

    // Cycle counter and sticky result registers.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cycle_count <= '0;
            stop_code   <= '0;
            timeout     <= 1'b0;
        end else if (enable) begin
            cycle_count <= cycle_count + CNT_W'(1);
            if (stop_hit) begin
                stop_code <= instr[1:0];
            end else if (limit_hit) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_boot_sequencer.sv
// Boot sequencer: streams source words into NUM_CH memory write ports,
// optionally zero-fills each memory, then runs the CPU until STOP or timeout.
module prog_boot_sequencer
    import prog_boot_sequencer_pkg::*;
#(
    parameter int unsigned          NUM_CH     = 2,
    parameter int unsigned          DATA_W     = 32,
    parameter int unsigned          ADDR_W     = 32,
    parameter logic [16*NUM_CH-1:0] CH_WORDS   = {16'd512, 16'd1024},
    parameter bit                   ZERO_FILL  = 1'b1,
    parameter logic [5:0]           STOP_OPC   = STOP_OPC_DEF,
    parameter int unsigned          MAX_CYCLES = 1000000,
    parameter int unsigned          CNT_W      = 32,
    localparam int unsigned         CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_last,
    output logic              src_ready,
    output logic [NUM_CH-1:0] ext_wen,
    output logic [NUM_CH-1:0] ext_ren,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_wdata,
    output logic              cpu_enable,
    input  logic [31:0]       instr,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [1:0]        stop_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CH_W-1:0]   cur_ch
);

    boot_state_e       state;
    logic [15:0]       word_idx;
    logic [15:0]       depth;
    logic [16:0]       last_idx;
    logic              at_last;
    logic              accept;
    logic              start_ok;
    logic              run_finish;
    logic [NUM_CH-1:0] ch_sel;

    // Per-channel decode, handshake and status derived from current state.
    always_comb begin
        depth     = ch_depth((16*MAX_CH)'(CH_WORDS), 32'(cur_ch));
        last_idx  = {1'b0, depth} - 17'd1;
        at_last   = ({1'b0, word_idx} == last_idx);
        src_ready = (state == ST_LOAD) && (depth != 16'd0);
        accept    = src_valid && src_ready;
        start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
        busy      = state inside {ST_LOAD, ST_FILL, ST_GAP, ST_RUN};
        ch_sel    = NUM_CH'(1) << cur_ch;
        ext_ren   = '0;
    end

    // Main sequencer FSM with the registered memory write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            word_idx   <= '0;
            cur_ch     <= '0;
            ext_wen    <= '0;
            ext_addr   <= '0;
            ext_wdata  <= '0;
            cpu_enable <= 1'b0;
            done       <= 1'b0;
        end else begin
            ext_wen <= '0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state    <= ST_LOAD;
                        cur_ch   <= '0;
                        word_idx <= '0;
                        done     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (depth == 16'd0) begin
                        state <= ST_GAP;
                    end else if (accept) begin
                        ext_wen   <= ch_sel;
                        ext_addr  <= ADDR_W'({word_idx, 2'b00});
                        ext_wdata <= src_data;
                        word_idx  <= word_idx + 16'd1;
                        // word_idx never exceeds depth-1, so !at_last means more room remains
                        if (src_last || at_last) begin
                            state <= (src_last && !at_last && ZERO_FILL) ? ST_FILL : ST_GAP;
                        end
                    end
                end
                ST_FILL: begin
                    ext_wen   <= ch_sel;
                    ext_addr  <= ADDR_W'({word_idx, 2'b00});
                    ext_wdata <= '0;
                    word_idx  <= word_idx + 16'd1;
                    if (at_last) begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    word_idx <= '0;
                    if (cur_ch == CH_W'(NUM_CH - 1)) begin
                        state      <= ST_RUN;
                        cpu_enable <= 1'b1;
                    end else begin
                        cur_ch <= cur_ch + CH_W'(1);
                        state  <= ST_LOAD;
                    end
                end
                ST_RUN: begin
                    if (run_finish) begin
                        state      <= ST_DONE;
                        cpu_enable <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    prog_run_monitor #(
        .STOP_OPC   (STOP_OPC),
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (CNT_W)
    ) u_run_monitor (
        .clk         (clk),
        .rst         (rst),
        .clear       (start_ok),
        .enable      (cpu_enable),
        .instr       (instr),
        .finish      (run_finish),
        .timeout     (timeout),
        .stop_code   (stop_code),
        .cycle_count (cycle_count)
    );

endmodule

// File: tb/tb_prog_boot_sequencer.sv
// Self-checking bench for prog_boot_sequencer: two instances cover
// zero-fill/stop behaviour (A) and no-fill/depth-0/timeout behaviour (B).
module tb_prog_boot_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned cyc     = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [1:0]  wen;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  wen;
        logic [31:0] addr;
    } vec_t;

    wr_t         exp_a[$];
    wr_t         exp_b[$];
    int unsigned stamp_a[$];
    wr_t         ea;
    wr_t         eb;

    // Instance A signals
    logic        rst_a, start_a, valid_a, last_a;
    logic [31:0] data_a, instr_a;
    logic        ready_a, en_a, busy_a, done_a, to_a;
    logic [1:0]  wen_a, ren_a, sc_a;
    logic [31:0] addr_a, wdata_a, cnt_a;
    logic [0:0]  ch_a;

    // Instance B signals
    logic        rst_b, start_b, valid_b, last_b;
    logic [31:0] data_b, instr_b;
    logic        ready_b, en_b, busy_b, done_b, to_b;
    logic [1:0]  wen_b, ren_b, sc_b;
    logic [31:0] addr_b, wdata_b, cnt_b;
    logic [0:0]  ch_b;

    prog_boot_sequencer #(
        .NUM_CH(2), .DATA_W(32), .ADDR_W(32), .CH_WORDS({16'd4, 16'd3}),
        .ZERO_FILL(1'b1), .STOP_OPC(6'b111110), .MAX_CYCLES(1000), .CNT_W(32)
    ) u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .src_valid(valid_a),
        .src_data(data_a), .src_last(last_a), .src_ready(ready_a),
        .ext_wen(wen_a), .ext_ren(ren_a), .ext_addr(addr_a), .ext_wdata(wdata_a),
        .cpu_enable(en_a), .instr(instr_a), .busy(busy_a), .done(done_a),
        .timeout(to_a), .stop_code(sc_a), .cycle_count(cnt_a), .cur_ch(ch_a)
    );

    prog_boot_sequencer #(
        .NUM_CH(2), .DATA_W(32), .ADDR_W(32), .CH_WORDS({16'd0, 16'd4}),
        .ZERO_FILL(1'b0), .STOP_OPC(6'b111110), .MAX_CYCLES(10), .CNT_W(32)
    ) u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .src_valid(valid_b),
        .src_data(data_b), .src_last(last_b), .src_ready(ready_b),
        .ext_wen(wen_b), .ext_ren(ren_b), .ext_addr(addr_b), .ext_wdata(wdata_b),
        .cpu_enable(en_b), .instr(instr_b), .busy(busy_b), .done(done_b),
        .timeout(to_b), .stop_code(sc_b), .cycle_count(cnt_b), .cur_ch(ch_b)
    );

    wire [107:0] outs_a = {ready_a, wen_a, ren_a, addr_a, wdata_a, en_a, busy_a,
                           done_a, to_a, sc_a, cnt_a, ch_a};
    wire [107:0] outs_b = {ready_b, wen_b, ren_b, addr_b, wdata_b, en_b, busy_b,
                           done_b, to_b, sc_b, cnt_b, ch_b};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Write scoreboards: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (wen_a !== 2'b00) begin
            stamp_a.push_back(cyc);
            if (exp_a.size() == 0) begin
                check("a_unexpected_write", {wen_a, addr_a, wdata_a}, 128'd0);
            end else begin
                ea = exp_a.pop_front();
                check("a_write", {wen_a, addr_a, wdata_a}, {ea.wen, ea.addr, ea.data});
            end
        end
    end

    always @(negedge clk) begin
        if (wen_b !== 2'b00) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected_write", {wen_b, addr_b, wdata_b}, 128'd0);
            end else begin
                eb = exp_b.pop_front();
                check("b_write", {wen_b, addr_b, wdata_b}, {eb.wen, eb.addr, eb.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog");
    end

    // All A tasks are entered and left 1 time unit after a rising edge.
    task automatic pulse_start_a();
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic send_a(input logic [31:0] d, input logic l, input logic [1:0] w,
                          input logic [31:0] ad);
        bit   got;
        wr_t  e;
        got     = 1'b0;
        valid_a = 1'b1;
        data_a  = d;
        last_a  = l;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready_a === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("a_src_ready_wait", ready_a, 1'b1);
        end else begin
            e.wen = w; e.addr = ad; e.data = d;
            exp_a.push_back(e);
        end
        @(posedge clk); #1;
        valid_a = 1'b0;
        last_a  = 1'b0;
    endtask

    task automatic push_a(input logic [1:0] w, input logic [31:0] ad, input logic [31:0] d);
        wr_t e;
        e.wen = w; e.addr = ad; e.data = d;
        exp_a.push_back(e);
    endtask

    // Runs A until the stop_at-th enabled cycle, drives STOP there, checks the result.
    task automatic run_a(input int unsigned stop_at, input logic [31:0] stop_instr,
                         input logic [1:0] code);
        int unsigned k;
        k = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (en_a === 1'b1) begin
                k++;
                if (k == 1) begin
                    check("a_run_busy", busy_a, 1'b1);
                    check("a_run_count_start", cnt_a, 32'd0);
                end
                if (k == stop_at) begin
                    instr_a = stop_instr;
                    break;
                end
            end
        end
        check("a_run_reached_stop", k, stop_at);
        @(negedge clk);
        instr_a = 32'd0;
        check("a_stop_cpu_enable", en_a, 1'b0);
        check("a_stop_done", done_a, 1'b1);
        check("a_stop_code", sc_a, code);
        check("a_stop_count", cnt_a, stop_at);
        check("a_stop_timeout", to_a, 1'b0);
        check("a_stop_busy", busy_a, 1'b0);
        check("a_all_writes_seen", exp_a.size(), 0);
        @(posedge clk); #1;
    endtask

    vec_t v1[7];
    vec_t v3[5];

    initial begin
        int unsigned kb;
        bit          got;
        wr_t         e;

        v1[0] = '{32'hA000_000A, 1'b0, 2'b01, 32'd0};
        v1[1] = '{32'hB000_000B, 1'b0, 2'b01, 32'd4};
        v1[2] = '{32'hC000_000C, 1'b1, 2'b01, 32'd8};
        v1[3] = '{32'hD000_000D, 1'b0, 2'b10, 32'd0};
        v1[4] = '{32'hE000_000E, 1'b0, 2'b10, 32'd4};
        v1[5] = '{32'hF000_000F, 1'b0, 2'b10, 32'd8};
        v1[6] = '{32'h1234_5678, 1'b1, 2'b10, 32'd12};

        // ch0 ends on depth (no src_last); ch1 keeps its own words
        v3[0] = '{32'h0000_1001, 1'b0, 2'b01, 32'd0};
        v3[1] = '{32'h0000_1002, 1'b0, 2'b01, 32'd4};
        v3[2] = '{32'h0000_1003, 1'b0, 2'b01, 32'd8};
        v3[3] = '{32'h0000_2001, 1'b0, 2'b10, 32'd0};
        v3[4] = '{32'h0000_2002, 1'b1, 2'b10, 32'd4};

        rst_a = 1'b1; start_a = 1'b0; valid_a = 1'b0; last_a = 1'b0;
        data_a = '0; instr_a = '0;
        rst_b = 1'b1; start_b = 1'b0; valid_b = 1'b0; last_b = 1'b0;
        data_b = '0; instr_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check("a_reset_state", outs_a, 108'd0);
        check("b_reset_state", outs_b, 108'd0);
        @(posedge clk); #1;

        // Session 1: two channels back-to-back, STOP at the 25th enabled cycle
        stamp_a.delete();
        pulse_start_a();
        for (int i = 0; i < 7; i++) send_a(v1[i].data, v1[i].last, v1[i].wen, v1[i].addr);
        run_a(25, 32'hF800_0001, 2'b01);
        check("a_write_count", stamp_a.size(), 7);
        if (stamp_a.size() == 7) begin
            check("a_ch0_back_to_back", stamp_a[1] - stamp_a[0], 1);
            check("a_gap_one_cycle", stamp_a[3] - stamp_a[2], 2);
            check("a_ch1_back_to_back", stamp_a[6] - stamp_a[5], 1);
        end

        // Session 2: restart from DONE, backpressure on ch0, zero-fill on ch1
        pulse_start_a();
        @(negedge clk);
        check("a_restart_done_clear", done_a, 1'b0);
        check("a_restart_count_clear", cnt_a, 32'd0);
        check("a_restart_code_clear", sc_a, 2'b00);
        check("a_restart_busy", busy_a, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            send_a(32'h5500_0000 + 32'(i), (i == 2), 2'b01, 32'(i) * 4);
            data_a = 32'hDEAD_0000 + 32'(i);
            last_a = 1'b1;
            @(posedge clk); #1;
            last_a = 1'b0;
        end
        send_a(32'h0000_0011, 1'b1, 2'b10, 32'd0);
        push_a(2'b10, 32'd4, 32'd0);
        push_a(2'b10, 32'd8, 32'd0);
        push_a(2'b10, 32'd12, 32'd0);
        valid_a = 1'b1;
        data_a  = 32'h0000_0BAD;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("a_fill_ready_low", ready_a, 1'b0);
        end
        @(posedge clk); #1;
        valid_a = 1'b0;
        run_a(1, 32'hFBFF_FFFE, 2'b10);

        // Session 3: reset while word 2 is offered, then a clean reload
        pulse_start_a();
        send_a(32'h7700_0000, 1'b0, 2'b01, 32'd0);
        send_a(32'h7700_0001, 1'b0, 2'b01, 32'd4);
        valid_a = 1'b1;
        data_a  = 32'h7700_0002;
        rst_a   = 1'b1;
        @(posedge clk); #1;
        rst_a   = 1'b0;
        valid_a = 1'b0;
        @(negedge clk);
        check("a_reset_midload", outs_a, 108'd0);
        @(posedge clk); #1;
        pulse_start_a();
        for (int i = 0; i < 5; i++) send_a(v3[i].data, v3[i].last, v3[i].wen, v3[i].addr);
        push_a(2'b10, 32'd8, 32'd0);
        push_a(2'b10, 32'd12, 32'd0);
        run_a(5, 32'hF800_0003, 2'b11);

        // Instance B: no zero-fill, depth-0 ch1, timeout at 10, start ignored in RUN
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        valid_b = 1'b1;
        data_b  = 32'h0000_0011;
        last_b  = 1'b1;
        got     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready_b === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("b_first_accept", got, 1'b1);
        e.wen = 2'b01; e.addr = 32'd0; e.data = 32'h0000_0011;
        exp_b.push_back(e);
        @(posedge clk); #1;
        data_b = 32'h0000_0BAD;
        last_b = 1'b0;
        kb = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (en_b === 1'b1) kb++;
            start_b = (en_b === 1'b1) && (kb == 3);
            if (done_b === 1'b1) break;
        end
        start_b = 1'b0;
        valid_b = 1'b0;
        check("b_done", done_b, 1'b1);
        check("b_timeout", to_b, 1'b1);
        check("b_cpu_enable_off", en_b, 1'b0);
        check("b_stop_code_zero", sc_b, 2'b00);
        check("b_cycle_count", cnt_b, 32'd10);
        check("b_enabled_cycles_seen", kb, 10);
        check("b_all_writes_seen", exp_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
